// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, class and select encodings for the multi-cycle controller.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_ILLEGAL
    } iclass_e;

    localparam logic [6:0] OP_ALU_R  = 7'h33;
    localparam logic [6:0] OP_ALU_I  = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;
endpackage

// File: rtl/ctrl_classify.sv
// ctrl_classify: maps opcode/f3/f7 to instruction class, illegal flag and ALU operation.
module ctrl_classify
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output iclass_e    cls,
    output logic       illegal,
    output logic [3:0] alu_op
);
    logic shift;

    always_comb begin
        cls     = C_ILLEGAL;
        illegal = 1'b0;
        alu_op  = ALU_ADD;
        shift   = f3[1:0] == 2'b01;
        case (opcode)
            OP_ALU_R: begin
                cls     = C_ALU_R;
                alu_op  = {f7[5], f3};
                illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_ALU_I: begin
                cls     = C_ALU_I;
                alu_op  = shift ? {f7[5], f3} : {1'b0, f3};
                // only SRAI may carry f7=0x20; other I-type f7 bits are immediate
                illegal = shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
            end
            OP_LUI:   cls = C_LUI;
            OP_AUIPC: cls = C_AUIPC;
            OP_JAL:   cls = C_JAL;
            OP_JALR: begin
                cls     = C_JALR;
                illegal = f3 != 3'b000;
            end
            OP_BRANCH: begin
                cls     = C_BRANCH;
                alu_op  = ALU_SUB;
                illegal = f3[2:1] == 2'b01;
            end
            OP_LOAD: begin
                cls     = C_LOAD;
                illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
            end
            OP_STORE: begin
                cls     = C_STORE;
                illegal = f3 > 3'b010;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer driving datapath enables/selects,
// memory handshakes and illegal-instruction / bus-timeout traps.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [3:0] alu_op,
    output logic       trap,
    output logic [1:0] cause,
    output logic [2:0] state
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    iclass_e         cls;
    logic            illegal;
    logic [3:0]      alu_op_c;

    ctrl_classify u_classify (
        .opcode  (opcode),
        .f3      (f3),
        .f7      (f7),
        .cls     (cls),
        .illegal (illegal),
        .alu_op  (alu_op_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign state = state_q;

    // Write strobes are gated by rst_n so a reset edge never commits PC/RF/IR.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        trap      = 1'b0;
        cause     = CAUSE_NONE;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = rst_n;
                    state_d = S_DECODE;
                end else if (cnt_q == CW'(MAX_WAIT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                state_d = illegal ? S_TRAP : S_EXEC;
                cause_d = illegal ? CAUSE_ILLEGAL : cause_q;
            end
            S_EXEC: begin
                alu_a_sel = cls == C_AUIPC;
                alu_b_sel = cls inside {C_ALU_I, C_LOAD, C_STORE, C_JALR, C_AUIPC};
                alu_op    = alu_op_c;
                if (cls == C_BRANCH) begin
                    pc_we   = rst_n;
                    pc_sel  = br_taken ? PC_REL : PC_PLUS4;
                    state_d = S_FETCH;
                end else begin
                    state_d = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls == C_STORE;
                if (dmem_ready) begin
                    pc_we   = rst_n && cls == C_STORE;
                    state_d = cls == C_STORE ? S_FETCH : S_WB;
                end else if (cnt_q == CW'(MAX_WAIT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                rf_we   = rst_n;
                pc_we   = rst_n;
                pc_sel  = cls == C_JAL ? PC_REL : cls == C_JALR ? PC_JALR : PC_PLUS4;
                wb_sel  = (cls == C_JAL || cls == C_JALR) ? WB_PC4 :
                          cls == C_LOAD ? WB_MEM : cls == C_LUI ? WB_IMM : WB_ALU;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap  = 1'b1;
                cause = cause_q;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback around the Decoder, register file, ALU and memories. It consumes the `opcode`, `f3` and `f7` fields from the Decoder and drives all datapath enables and selects. It owns the instruction/data memory request handshakes and traps on illegal encodings or memory timeouts.

## Interface
- `MAX_WAIT`, default 255: memory wait cycles tolerated before a bus-error trap; counter width is $clog2(MAX_WAIT+1).
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7, `f3` in 3, `f7` in 7: instruction fields from the Decoder.
- `br_taken` in 1: branch comparator result, valid in EXEC.
- `imem_req` out 1 / `imem_ready` in 1: instruction fetch handshake.
- `dmem_req` out 1, `dmem_we` out 1 / `dmem_ready` in 1: data access handshake.
- `ir_we` out 1: latch the fetched instruction.
- `pc_we` out 1, `pc_sel` out 2: PC source select. 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1.
- `rf_we` out 1, `wb_sel` out 2: writeback source select. 0 = ALU, 1 = memory, 2 = pc+4, 3 = imm.
- `alu_a_sel` out 1 (0 = rs1, 1 = pc), `alu_b_sel` out 1 (0 = rs2, 1 = imm), `alu_op` out 4.
- `trap` out 1, `cause` out 2: 1 = illegal instruction, 2 = imem timeout, 3 = dmem timeout.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore, decoded from the state register and the current fields.
- IDLE: all outputs 0; moves to FETCH unconditionally.
- FETCH: `imem_req`=1. On `imem_ready`: pulse `ir_we` and go to DECODE.
- DECODE: one cycle, which covers the Decoder's registered immediate. Illegal encoding goes to TRAP with cause 1; otherwise EXEC.
- EXEC: drives the ALU selects and `alu_op`.
  - ALU-R, ALU-I, LUI, AUIPC, JAL, JALR go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: `pc_we`=1, `pc_sel`=1 if `br_taken`, else 0; then FETCH.
- MEM: `dmem_req`=1, `dmem_we`=1 for STORE. On `dmem_ready`, LOAD goes to WB. STORE asserts `pc_we` (`pc_sel`=0) and goes to FETCH.
- WB: `rf_we`=1 and `pc_we`=1, then FETCH.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
  - `wb_sel`: 2 for JAL/JALR, 1 for LOAD, 3 for LUI, 0 otherwise.
- TRAP: `trap`=1 and `cause` holds; stays until reset. No `pc_we` or `rf_we`.
- `alu_op` encoding:
  - R-type: {f7[5], f3}.
  - Shift-immediate: {f7[5], f3}.
  - Other ALU-I: {0, f3}.
  - LOAD, STORE, JALR, AUIPC: 0000 (add).
  - BRANCH: 1000 (sub).
- Illegal encodings:
  - Unknown opcode, including FENCE and SYSTEM.
  - R-type with f7 not 0x00/0x20, or f7=0x20 with f3 other than 000/101.
  - Shift-immediate (f3 = 001 or 101) with an invalid f7.
  - BRANCH with f3 = 010 or 011.
  - LOAD with f3 = 011, 110 or 111.
  - STORE with f3 > 010.
  - JALR with f3 ≠ 000.

## Timing
- Reset: state=IDLE and every output 0, including `trap`, `cause` and `alu_op`. Reset mid-transaction drops `req` on the next edge; no PC or RF write occurs.
- Handshake:
  - `req` holds high until `ready` is sampled high in the same cycle.
  - `ready` with `req` low is ignored.
  - Zero-wait memory, with `ready` in the first `req` cycle, is accepted.
- Latency with zero wait (FETCH entry to next FETCH entry): branch 3 cycles; ALU, LUI, AUIPC, JAL, JALR and STORE 4; LOAD 5. Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle `ready` is low.
  - When it reaches MAX_WAIT with `ready` still low, the next state is TRAP, with cause 2 (from FETCH) or 3 (from MEM).
  - If `ready` arrives in the same cycle as the limit, the access completes normally.

## Structure
- `ctrl_pkg`: state enum, opcode localparams, `alu_op`, `pc_sel`, `wb_sel` and `cause` codes.
- One sub-module, `ctrl_classify`: combinational mapping of opcode/f3/f7 to instruction class, illegal flag and `alu_op`.

## Test plan
- `add` (0x33, f3 0, f7 0x00), zero-wait → `alu_op`=0000 in EXEC, `rf_we`=1 and `wb_sel`=0 in WB, next FETCH 4 cycles after entry.
- `lw` with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, `wb_sel`=1, total 8 cycles.
- `beq` with `br_taken`=1, then `br_taken`=0 → `pc_sel`=1, then 0, in EXEC; `rf_we` never asserted.
- `jalr` with f3=001 → TRAP, `cause`=1, `trap` held 10 cycles, no `pc_we`.
- `imem_ready` held low, MAX_WAIT=4 → TRAP with `cause`=2 after 5 FETCH cycles; `rst_n`=0 → IDLE with all outputs 0.
- `rst_n` pulsed during MEM of `sw` → `dmem_req` low next cycle, no `pc_we`, restart IDLE→FETCH.
